// File: rtl/zdram_cpuport.sv
// CPU-side DRAM port: queues one Z80 access, issues it into a free DRAM slot, returns data with a strobe.
// Optional one-word read cache compiled in with `define ZDRAM_CPUPORT_RDCACHE_EN.
module zdram_cpuport (
    input  logic        fclk,
    input  logic        rst,
    input  logic        cend,
    input  logic        pre_cend,
    input  logic        dram_slot_free,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [7:0]  cpu_wrdata,
    input  logic        cpu_wrbsel,
    output logic [15:0] cpu_rddata,
    output logic        cpu_strobe,
    output logic        cpu_stall,
    output logic        cpu_ovr,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    output logic [1:0]  dram_bsel,
    input  logic [15:0] dram_rddata
);

    typedef enum logic [1:0] {IDLE, PEND, ISSUED, ACT} state_t;

    state_t      state_q, state_d;
    logic        dram_req_q, dram_req_d;
    logic        rnw_q, rnw_d;
    logic [20:0] addr_q, addr_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic        wrbsel_q, wrbsel_d;
    logic [15:0] rddata_q, rddata_d;
    logic        strobe_q, strobe_d;
    logic        ovr_q, ovr_d;
    logic        busy;
    logic        cache_hit;
    logic        cache_wmatch;
    logic [15:0] cache_rd;

`ifdef ZDRAM_CPUPORT_RDCACHE_EN
    logic        valid_q, valid_d;
    logic [20:0] tag_q, tag_d;
    logic [15:0] cdata_q, cdata_d;

    assign cache_hit    = cpu_rnw & valid_q & (tag_q == cpu_addr);
    assign cache_wmatch = ~cpu_rnw & valid_q & (tag_q == cpu_addr);
    assign cache_rd     = cdata_q;
`else
    assign cache_hit    = 1'b0;
    assign cache_wmatch = 1'b0;
    assign cache_rd     = 16'h0000;
`endif

    always_comb begin
        state_d    = state_q;
        dram_req_d = dram_req_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        wrbsel_d   = wrbsel_q;
        rddata_d   = rddata_q;
        strobe_d   = 1'b0;
        ovr_d      = ovr_q;
`ifdef ZDRAM_CPUPORT_RDCACHE_EN
        valid_d    = valid_q;
        tag_d      = tag_q;
        cdata_d    = cdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (cache_hit) begin
                        rddata_d = cache_rd;
                        strobe_d = 1'b1;
                    end else begin
                        rnw_d    = cpu_rnw;
                        addr_d   = cpu_addr;
                        wrdata_d = cpu_wrdata;
                        wrbsel_d = cpu_wrbsel;
                        if (pre_cend && dram_slot_free) begin
                            state_d    = ISSUED;
                            dram_req_d = 1'b1;
                        end else begin
                            state_d = PEND;
                        end
                    end
`ifdef ZDRAM_CPUPORT_RDCACHE_EN
                    // Write-through: keep the cached word coherent before DRAM sees the write.
                    if (cache_wmatch) begin
                        if (cpu_wrbsel) cdata_d[7:0]  = cpu_wrdata;
                        else            cdata_d[15:8] = cpu_wrdata;
                    end
`endif
                end
            end
            PEND: begin
                if (pre_cend && dram_slot_free) begin
                    state_d    = ISSUED;
                    dram_req_d = 1'b1;
                end
            end
            ISSUED: begin
                if (cend) begin
                    dram_req_d = 1'b0;
                    state_d    = ACT;
                end
            end
            ACT: begin
                if (cend) begin
                    if (rnw_q) begin
                        rddata_d = dram_rddata;
`ifdef ZDRAM_CPUPORT_RDCACHE_EN
                        valid_d  = 1'b1;
                        tag_d    = addr_q;
                        cdata_d  = dram_rddata;
`endif
                    end
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Only one access is held; anything arriving while busy is lost.
        if (cpu_req && (state_q != IDLE)) ovr_d = 1'b1;
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dram_req_q <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= 21'h0;
            wrdata_q   <= 8'h0;
            wrbsel_q   <= 1'b0;
            rddata_q   <= 16'h0;
            strobe_q   <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dram_req_q <= dram_req_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            wrbsel_q   <= wrbsel_d;
            rddata_q   <= rddata_d;
            strobe_q   <= strobe_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef ZDRAM_CPUPORT_RDCACHE_EN
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= 21'h0;
            cdata_q <= 16'h0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cdata_q <= cdata_d;
        end
    end
`endif

    // DRAM-side outputs are gated to zero while idle so reset values are all-zero.
    assign busy        = (state_q != IDLE);
    assign dram_req    = dram_req_q;
    assign dram_rnw    = busy & rnw_q;
    assign dram_addr   = busy ? addr_q : 21'h0;
    assign dram_wrdata = busy ? {wrdata_q, wrdata_q} : 16'h0;
    assign dram_bsel   = !busy ? 2'b00 : (rnw_q ? 2'b11 : {~wrbsel_q, wrbsel_q});
    assign cpu_stall   = cpu_req | busy;
    assign cpu_rddata  = rddata_q;
    assign cpu_strobe  = strobe_q;
    assign cpu_ovr     = ovr_q;

endmodule

// File: tb/tb_zdram_cpuport.sv
// Directed bench for zdram_cpuport: free-running DRAM cycle (N=4) and a read-data scoreboard on cpu_strobe.
module tb_zdram_cpuport;

    localparam int N = 4;

    logic        fclk = 1'b0;
    logic        rst;
    logic        cend;
    logic        pre_cend;
    logic        dram_slot_free;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [20:0] cpu_addr;
    logic [7:0]  cpu_wrdata;
    logic        cpu_wrbsel;
    logic [15:0] cpu_rddata;
    logic        cpu_strobe;
    logic        cpu_stall;
    logic        cpu_ovr;
    logic        dram_req;
    logic        dram_rnw;
    logic [20:0] dram_addr;
    logic [15:0] dram_wrdata;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_rddata;
    logic [15:0] rd_word;

    int checks = 0;
    int errors = 0;
    int pos_cnt = 0;
    int cnt = 0;
    int req_rises = 0;
    int req_hi = 0;
    logic req_prev = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] model_rd;
    logic [15:0] mon_e;

    assign dram_rddata = rd_word;

    zdram_cpuport dut (
        .fclk(fclk), .rst(rst), .cend(cend), .pre_cend(pre_cend),
        .dram_slot_free(dram_slot_free), .cpu_req(cpu_req), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_wrbsel(cpu_wrbsel),
        .cpu_rddata(cpu_rddata), .cpu_strobe(cpu_strobe), .cpu_stall(cpu_stall),
        .cpu_ovr(cpu_ovr), .dram_req(dram_req), .dram_rnw(dram_rnw),
        .dram_addr(dram_addr), .dram_wrdata(dram_wrdata), .dram_bsel(dram_bsel),
        .dram_rddata(dram_rddata)
    );

    // Clock and reset block
    initial forever #5 fclk = ~fclk;

    // DRAM cycle generator: pre_cend then cend every N fclk
    initial begin
        pre_cend = 1'b0;
        cend     = 1'b0;
        forever begin
            @(posedge fclk);
            pos_cnt++;
            #1;
            cnt      = (cnt + 1) % N;
            pre_cend = (cnt == 2);
            cend     = (cnt == 3);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected read word
    initial forever begin
        @(negedge fclk);
        if (dram_req === 1'b1) req_hi++;
        if (dram_req === 1'b1 && req_prev !== 1'b1) req_rises++;
        req_prev = dram_req;
        if (cpu_strobe === 1'b1) begin
            check("strobe_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rddata", {16'b0, cpu_rddata}, {16'b0, mon_e});
            end
        end
    end

    // Driver tasks
    task automatic wait_cnt(input int k);
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge fclk);
            if (cnt == k) break;
        end
    endtask

    task automatic wait_pre();
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge fclk);
            if (pre_cend) break;
        end
    endtask

    task automatic wait_strobe(output int at);
        at = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge fclk);
            if (cpu_strobe === 1'b1) begin
                at = pos_cnt;
                break;
            end
        end
        if (at < 0) check("strobe_timeout", {31'b0, cpu_strobe}, 32'd1);
    endtask

    task automatic drive_req(input logic rnw, input logic [20:0] a, input logic [7:0] d, input logic bs);
        cpu_req    = 1'b1;
        cpu_rnw    = rnw;
        cpu_addr   = a;
        cpu_wrdata = d;
        cpu_wrbsel = bs;
    endtask

    initial begin
        int p0, at, base, hbase;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_addr = '0; cpu_wrdata = '0; cpu_wrbsel = 1'b0;
        dram_slot_free = 1'b1;
        rd_word = 16'h0;
        model_rd = 16'h0;
        repeat (3) @(negedge fclk);
        check("rst_rddata", {16'b0, cpu_rddata}, 32'h0);
        check("rst_strobe", {31'b0, cpu_strobe}, 32'h0);
        check("rst_stall", {31'b0, cpu_stall}, 32'h0);
        check("rst_ovr", {31'b0, cpu_ovr}, 32'h0);
        check("rst_dram_req", {31'b0, dram_req}, 32'h0);
        check("rst_dram_bsel", {30'b0, dram_bsel}, 32'h0);
        check("rst_dram_addr", {11'b0, dram_addr}, 32'h0);
        rst = 1'b0;
        @(negedge fclk);

        // Read, slot free, request lands on pre_cend
        rd_word = 16'hA55A;
        wait_cnt(2);
        base = req_rises; hbase = req_hi;
        drive_req(1'b1, 21'h01234, 8'h00, 1'b0);
        exp_q.push_back(16'hA55A); model_rd = 16'hA55A;
        p0 = pos_cnt;
        #1 check("rd_stall_same_cycle", {31'b0, cpu_stall}, 32'd1);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("rd_dram_req", {31'b0, dram_req}, 32'd1);
        check("rd_dram_addr", {11'b0, dram_addr}, 32'h01234);
        check("rd_dram_bsel", {30'b0, dram_bsel}, 32'h3);
        wait_strobe(at);
        check("rd_latency", at - (p0 + 1), 1 + N);
        check("rd_stall_release", {31'b0, cpu_stall}, 32'd0);
        check("rd_req_pulses", req_rises - base, 32'd1);
        check("rd_req_width", req_hi - hbase, 32'd1);

        // Write, low byte, queued in PEND
        wait_cnt(0);
        base = req_rises;
        drive_req(1'b0, 21'h00155, 8'h3C, 1'b1);
        exp_q.push_back(model_rd);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("wr_dram_wrdata", {16'b0, dram_wrdata}, 32'h3C3C);
        check("wr_dram_bsel", {30'b0, dram_bsel}, 32'h1);
        check("wr_dram_rnw", {31'b0, dram_rnw}, 32'h0);
        check("wr_pend_no_req", {31'b0, dram_req}, 32'h0);
        check("wr_stall", {31'b0, cpu_stall}, 32'd1);
        wait_strobe(at);
        check("wr_req_pulses", req_rises - base, 32'd1);

        // Slot refused twice, max address
        dram_slot_free = 1'b0;
        rd_word = 16'h0F0F;
        wait_cnt(0);
        base = req_rises;
        drive_req(1'b1, 21'h1FFFFF, 8'h00, 1'b0);
        exp_q.push_back(16'h0F0F); model_rd = 16'h0F0F;
        @(negedge fclk);
        cpu_req = 1'b0;
        wait_pre();
        p0 = pos_cnt;
        wait_pre();
        @(negedge fclk);
        dram_slot_free = 1'b1;
        wait_pre();
        check("ref_no_req_yet", req_rises - base, 32'd0);
        check("ref_dram_addr", {11'b0, dram_addr}, 32'h1FFFFF);
        wait_strobe(at);
        check("ref_latency", at - (p0 + 1), 1 + 3 * N);
        check("ref_req_pulses", req_rises - base, 32'd1);

        // Overrun on the completing cend
        rd_word = 16'h2468;
        wait_cnt(2);
        base = req_rises;
        drive_req(1'b1, 21'h00020, 8'h00, 1'b0);
        exp_q.push_back(16'h2468); model_rd = 16'h2468;
        @(negedge fclk);
        cpu_req = 1'b0;
        wait_cnt(3);
        check("ovr_before", {31'b0, cpu_ovr}, 32'd0);
        drive_req(1'b1, 21'h00077, 8'h00, 1'b0);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("ovr_cend_strobe", {31'b0, cpu_strobe}, 32'd1);
        check("ovr_cend_set", {31'b0, cpu_ovr}, 32'd1);

        // Overrun mid-ACT; flag stays set, one access only
        rd_word = 16'h1357;
        wait_cnt(2);
        drive_req(1'b1, 21'h00030, 8'h00, 1'b0);
        exp_q.push_back(16'h1357); model_rd = 16'h1357;
        @(negedge fclk);
        cpu_req = 1'b0;
        @(negedge fclk);
        drive_req(1'b0, 21'h00031, 8'h55, 1'b1);
        @(negedge fclk);
        cpu_req = 1'b0;
        wait_strobe(at);
        repeat (3 * N) @(negedge fclk);
        check("ovr_sticky", {31'b0, cpu_ovr}, 32'd1);
        check("ovr_req_pulses", req_rises - base, 32'd2);

        // Reset while ISSUED
        wait_cnt(2);
        drive_req(1'b1, 21'h00400, 8'h00, 1'b0);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("rstmid_issued", {31'b0, dram_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_dram_req", {31'b0, dram_req}, 32'd0);
        check("rstmid_stall", {31'b0, cpu_stall}, 32'd0);
        check("rstmid_strobe", {31'b0, cpu_strobe}, 32'd0);
        check("rstmid_ovr", {31'b0, cpu_ovr}, 32'd0);
        model_rd = 16'h0;
        @(negedge fclk);
        rst = 1'b0;
        repeat (4 * N) @(negedge fclk);
        check("rstmid_rddata", {16'b0, cpu_rddata}, 32'h0);

        // Read 0x10 (cache miss when the cache is built in)
        rd_word = 16'h1234;
        wait_cnt(0);
        drive_req(1'b1, 21'h00010, 8'h00, 1'b0);
        exp_q.push_back(16'h1234); model_rd = 16'h1234;
        @(negedge fclk);
        cpu_req = 1'b0;
        wait_strobe(at);
        rd_word = 16'hDEAD;
        repeat (2) @(negedge fclk);
        base = req_rises;
`ifdef ZDRAM_CPUPORT_RDCACHE_EN
        drive_req(1'b1, 21'h00010, 8'h00, 1'b0);
        exp_q.push_back(16'h1234);
        #1 check("hit_stall", {31'b0, cpu_stall}, 32'd1);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("hit_strobe", {31'b0, cpu_strobe}, 32'd1);
        check("hit_stall_release", {31'b0, cpu_stall}, 32'd0);
        check("hit_no_dram", req_rises - base, 32'd0);
        wait_cnt(0);
        drive_req(1'b0, 21'h00010, 8'hEE, 1'b0);
        exp_q.push_back(16'h1234);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("wt_bsel", {30'b0, dram_bsel}, 32'h2);
        wait_strobe(at);
        check("wt_goes_to_dram", req_rises - base, 32'd1);
        repeat (2) @(negedge fclk);
        drive_req(1'b1, 21'h00010, 8'h00, 1'b0);
        exp_q.push_back(16'hEE34);
        @(negedge fclk);
        cpu_req = 1'b0;
        check("hit2_strobe", {31'b0, cpu_strobe}, 32'd1);
        check("hit2_high_byte", {24'b0, cpu_rddata[15:8]}, 32'hEE);
        check("hit2_no_dram", req_rises - base, 32'd1);
`else
        wait_cnt(0);
        drive_req(1'b1, 21'h00010, 8'h00, 1'b0);
        exp_q.push_back(16'hDEAD);
        @(negedge fclk);
        cpu_req = 1'b0;
        wait_strobe(at);
        check("nocache_dram", req_rises - base, 32'd1);
`endif

        repeat (2 * N) @(negedge fclk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zdram_cpuport.md
# zdram_cpuport

CPU-side DRAM port for the Z80 memory path. It accepts single-pulse requests from the Z80 memory manager (`cpu_req`/`cpu_rnw`/`cpu_addr`/`cpu_wrdata`/`cpu_wrbsel`) and queues one access at a time. It issues that access into a free DRAM cycle slot, returns the 16-bit read word with a one-`fclk` `cpu_strobe`, and holds `cpu_stall` toward the Z80 clock generator while an access is outstanding.

## Interface
Parameters: none.

Ports:
- `fclk` in 1: system clock; everything is sampled on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cend` in 1: DRAM cycle end strobe, one `fclk` wide.
- `pre_cend` in 1: strobe one `fclk` before `cend`. Never coincides with `cend`.
- `dram_slot_free` in 1: arbiter indicates the next DRAM cycle may go to the CPU. Valid when `pre_cend`=1.
- `cpu_req` in 1: request pulse from the memory manager.
- `cpu_rnw` in 1: 1 = read, 0 = write. Sampled with `cpu_req`.
- `cpu_addr` in 21: word address.
- `cpu_wrdata` in 8: write byte.
- `cpu_wrbsel` in 1: byte select. 1 = low byte [7:0], 0 = high byte [15:8].
- `cpu_rddata` out 16: read word. Stable from `cpu_strobe` until the next capture.
- `cpu_strobe` out 1: one-`fclk` completion pulse for both reads and writes.
- `cpu_stall` out 1: access outstanding; holds the Z80 clock.
- `cpu_ovr` out 1: sticky flag. Set when a request is dropped.
- `dram_req` out 1: request to the DRAM controller. The controller samples it at `cend`.
- `dram_rnw` out 1: access direction.
- `dram_addr` out 21: DRAM word address.
- `dram_wrdata` out 16: write data.
- `dram_bsel` out 2: byte enables, [1]=high, [0]=low.
- `dram_rddata` in 16: read data. Valid at the `cend` that ends the CPU cycle.

## Operation
- State machine states: IDLE, PEND, ISSUED, ACT.
- **IDLE**
  - On `cpu_req`, latch `rnw`, `addr`, `wrdata` and `wrbsel`, then go to PEND.
  - If `pre_cend`=1 and `dram_slot_free`=1 in the same cycle, go directly to ISSUED with `dram_req`<=1.
- **PEND**
  - On `pre_cend` with `dram_slot_free`=1: `dram_req`<=1, go to ISSUED.
  - On `pre_cend` with `dram_slot_free`=0: stay in PEND and retry at the next `pre_cend`. There is no bound on the number of retries.
- **ISSUED**
  - On `cend`: `dram_req`<=0, go to ACT.
- **ACT**
  - On `cend`: for a read, `cpu_rddata`<=`dram_rddata`.
  - Pulse `cpu_strobe` for one `fclk`, then go to IDLE.
- **DRAM output encoding**
  - `dram_addr`/`dram_rnw` are driven from the latched request while in PEND, ISSUED and ACT.
  - `dram_wrdata` = {wrdata, wrdata}.
  - `dram_bsel` = {~wrbsel, wrbsel} for writes, 2'b11 for reads.
- **Stall and overrun**
  - `cpu_stall` = `cpu_req` | (state != IDLE). It is combinational, so the same-cycle request stalls.
  - `cpu_req` outside IDLE is dropped and sets `cpu_ovr`. Only reset clears `cpu_ovr`.
  - `cpu_req` in the same cycle as the ACT-completing `cend` is also dropped, with `cpu_ovr` set.
- **Reset**
  - All outputs reset to 0 and the state to IDLE, asynchronously.
  - A reset in mid-access abandons the access.
  - The DRAM controller sees `dram_req` fall and treats the abandoned cycle as idle.

## Timing
- **Miss latency.** Measured from the `pre_cend` edge with `dram_slot_free`=1, `cpu_strobe` is asserted 1 + N `fclk` later, where N is the DRAM cycle length in `fclk` (the `cend`-to-`cend` interval).
- **Slot waits.** Each refused slot adds one full DRAM cycle.
- **`dram_req` window.** `dram_req` is high for exactly one `fclk`: from the `fclk` after `pre_cend` through the `cend` that samples it.
- **Strobe placement.** `cpu_strobe` lands in the `fclk` after the completing `cend`, coincident with the `cpu_rddata` update.
- **Stall release.** `cpu_stall` drops in the same `fclk` as `cpu_strobe`.

## Configuration
- **Macro:** `ZDRAM_CPUPORT_RDCACHE_EN`.
- **Defined:** a one-word read cache is compiled in.
  - It holds a valid bit, a 21-bit tag and 16-bit data.
  - **Read hit** (valid and tag = `cpu_addr`, in IDLE): `cpu_rddata`<=cache data and `cpu_strobe` pulses in the next `fclk`. No DRAM cycle is issued; `cpu_stall` is high for that one `fclk` only.
  - **Read miss:** follows the normal path. At completion it fills the cache: tag<=addr, data<=`dram_rddata`, valid<=1.
  - **Write to the cached word:** updates the selected byte of the cached data at request-latch time. The write still goes to DRAM (write-through).
  - Reset clears the valid bit.
- **Not defined:** every read goes to DRAM, and the cache registers do not exist.

## Test plan
- **Read, slot free:** `cpu_addr`=21'h01234, `rnw`=1, `dram_rddata`=16'hA55A at completion, N=4 → `dram_req` pulses once; `cpu_strobe` arrives 5 `fclk` after `pre_cend`; `cpu_rddata`=16'hA55A; `cpu_stall` falls with the strobe.
- **Write, low byte:** `wrbsel`=1, `wrdata`=8'h3C → `dram_wrdata`=16'h3C3C, `dram_bsel`=2'b01, `dram_rnw`=0; `cpu_strobe` pulses; `cpu_rddata` is unchanged.
- **Slot refused:** `dram_slot_free`=0 for 2 `pre_cend`s, then 1 → `dram_req` is raised only after the third `pre_cend`; strobe latency is 2N longer than the free case.
- **Overrun:** second `cpu_req` while in ACT → `cpu_ovr`=1 and stays 1; exactly one DRAM access and one strobe occur.
- **Reset mid-access:** assert `rst` while in ISSUED → `dram_req`, `cpu_stall` and `cpu_strobe` go to 0 immediately; no strobe after reset is released.
- **With `ZDRAM_CPUPORT_RDCACHE_EN`:**
  - Read 21'h00010 (miss), then read 21'h00010 again → the second read gives `cpu_strobe` 1 `fclk` after `cpu_req` with no `dram_req`.
  - Write high byte 8'hEE to 21'h00010, then read it → the read hits, and `cpu_rddata[15:8]`=8'hEE.
